// File: rtl/block_writeback_64_pkg.sv
// Shared types and widths for the 8x8 block loader/writer pair.
// WB_SAT_EN selects saturating (vs truncating) element conversion.
package block_writeback_64_pkg;
  localparam int N      = 8;
  localparam int BLK    = N * N;
  localparam int AW_DEF = 18;
  localparam int DW_DEF = 16;
  localparam int EW_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam logic signed [EW_DEF-1:0] CONV_MAX =
    $signed({{(EW_DEF-DW_DEF+1){1'b0}}, {(DW_DEF-1){1'b1}}});
  localparam logic signed [EW_DEF-1:0] CONV_MIN = ~CONV_MAX;

  function automatic logic [DW_DEF-1:0] conv(
    input logic signed [EW_DEF-1:0] x
  );
`ifdef WB_SAT_EN
    if (x > CONV_MAX)
      return {1'b0, {(DW_DEF-1){1'b1}}};
    else if (x < CONV_MIN)
      return {1'b1, {(DW_DEF-1){1'b0}}};
    else
      return x[DW_DEF-1:0];
`else
    return x[DW_DEF-1:0];
`endif
  endfunction
endpackage

// File: rtl/block_writeback_64_conv.sv
// Signed EW-bit to DW-bit element converter.
// WB_SAT_EN: clamp to DW range; otherwise two's-complement wrap.
module wb_sat_conv #(
  parameter int EW = 22,
  parameter int DW = 16
) (
  input  logic [EW-1:0] x_i,
  output logic [DW-1:0] y_o
);
`ifdef WB_SAT_EN
  localparam logic signed [EW-1:0] MAXV =
    $signed({{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  always_comb begin
    y_o = x_i[DW-1:0];
    if ($signed(x_i) > MAXV)
      y_o = {1'b0, {(DW-1){1'b1}}};
    else if ($signed(x_i) < MINV)
      y_o = {1'b1, {(DW-1){1'b0}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^x_i[EW-1:DW];
  assign y_o = x_i[DW-1:0];
`endif
endmodule

// File: rtl/counterr.sv
// Clearable up-counter with synchronous active-high reset.
// Wraps modulo 2^W.
module counterr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (en)
      q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/block_writeback_64.sv
// Buffers eight rows of an 8x8 block, then writes 64 words to SRAM.
// WB_SAT_EN selects saturating element conversion.
module block_writeback_64
  import block_writeback_64_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic            row_valid,
  output logic            row_ready,
  input  logic [EW*N-1:0] row_in,
  output logic            w_en,
  output logic [AW-1:0]   w_addr,
  output logic [DW-1:0]   w_data,
  output logic            busy,
  output logic            done
);
  wb_state_e     state_q, state_d;
  logic [AW-1:0] base_q;
  logic [EW-1:0] buf_q [N][N];
  logic [2:0]    rcnt_q;
  logic [5:0]    wcnt_q;
  logic          accept, hs, wr;
  logic [EW-1:0] elem;
  logic [DW-1:0] conv_y;

  assign accept = (state_q == ST_IDLE) && start;
  assign hs     = row_ready && row_valid;
  assign wr     = (state_q == ST_WRITE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (hs && rcnt_q == 3'd7) state_d = ST_WRITE;
      ST_WRITE: if (wcnt_q == 6'd63) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        base_q <= base_addr;
    end
  end

  // Row buffer is deliberately not reset; every entry is rewritten before use.
  always_ff @(posedge clock) begin
    if (hs)
      for (int c = 0; c < N; c++)
        buf_q[rcnt_q][c] <= row_in[EW*(N-c)-1 -: EW];
  end

  counterr #(.W(3)) u_row_cnt (
    .clk (clock),
    .rst (reset),
    .clr (accept),
    .en  (hs),
    .q   (rcnt_q)
  );

  counterr #(.W(6)) u_wr_cnt (
    .clk (clock),
    .rst (reset),
    .clr (accept),
    .en  (wr),
    .q   (wcnt_q)
  );

  assign elem = buf_q[wcnt_q[5:3]][wcnt_q[2:0]];

  wb_sat_conv #(.EW(EW), .DW(DW)) u_conv (
    .x_i (elem),
    .y_o (conv_y)
  );

  assign row_ready = (state_q == ST_FILL);
  assign w_en      = wr;
  assign w_addr    = wr ? base_q + AW'(wcnt_q) : '0;
  assign w_data    = wr ? conv_y : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_block_writeback_64.sv
// Directed + random bench for block_writeback_64 with a block-level
// reference model (matrix in, ordered write list out).
module tb_block_writeback_64;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int EW = 22;
  localparam int N  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            row_valid;
  logic            row_ready;
  logic [EW*N-1:0] row_in;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  logic signed [EW-1:0] blk [64];

  block_writeback_64 dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_in    (row_in),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_conv(input logic signed [EW-1:0] e);
    int v;
    v = int'(e);
`ifdef WB_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  // stall: random row_valid gaps; abort_k: assert reset at that write (-1 none);
  // hold: keep start high for the whole block.
  task automatic run_block(input logic [AW-1:0] base, input bit stall,
                           input int abort_k, input bit hold);
    int r;
    int cyc;
    bit v;
    bit rdy;
    logic [AW-1:0] ea;
    @(negedge clock);
    start = 1'b1;
    base_addr = base;
    @(negedge clock);
    start = hold;
    base_addr = ~base;
    chk("busy_fill", 32'(busy), 32'd1);
    r = 0;
    cyc = 0;
    while (r < 8 && cyc < 300) begin
      chk("no_early_wen", 32'(w_en), 32'd0);
      chk("ready_fill", 32'(row_ready), 32'd1);
      rdy = row_ready;
      v = stall ? (($urandom_range(0, 2) == 0) || (cyc % 7 == 6)) : 1'b1;
      row_valid = v;
      for (int c = 0; c < N; c++)
        row_in[EW*(N-c)-1 -: EW] = v ? blk[r*8+c] : EW'($urandom);
      if (v && rdy) r++;
      @(negedge clock);
      cyc++;
    end
    row_valid = 1'b0;
    chk("fill_timeout", 32'(r), 32'd8);
    chk("ready_drop", 32'(row_ready), 32'd0);
    for (int k = 0; k < 64; k++) begin
      ea = base + AW'(k);
      chk("wen", 32'(w_en), 32'd1);
      chk("waddr", 32'(w_addr), 32'(ea));
      chk("wdata", 32'(w_data), 32'(ref_conv(blk[k])));
      chk("no_early_done", 32'(done), 32'd0);
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clock);
        chk("abort_wen", 32'(w_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clock);
    end
    chk("last_wen_off", 32'(w_en), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clock);
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(row_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_valid = 1'b0;
    row_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(row_ready), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'd0);
    chk("rst_wdata", 32'(w_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    // ramp
    for (int i = 0; i < 64; i++) blk[i] = EW'(i);
    run_block(18'h00100, 1'b0, -1, 1'b0);

    // conversion corners mixed with random values
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom);
    blk[0] = 22'sd40000;
    blk[1] = -22'sd40000;
    blk[2] = -22'sd5;
    blk[3] = 22'sd32767;
    blk[4] = -22'sd32768;
    blk[5] = 22'sd32768;
    blk[6] = -22'sd32769;
    run_block(18'h01234, 1'b0, -1, 1'b0);

    // row stalls with random data
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom);
    run_block(18'h2A5A0, 1'b1, -1, 1'b0);

    // address wrap
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom_range(0, 70000)) - 22'sd35000;
    run_block(18'h3FFF0, 1'b1, -1, 1'b0);

    // reset at k=20, then a fresh block
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom);
    run_block(18'h00400, 1'b0, 20, 1'b0);
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom);
    run_block(18'h00800, 1'b1, -1, 1'b0);

    // start held high across FILL/WRITE/DONE
    for (int i = 0; i < 64; i++) blk[i] = EW'($urandom);
    run_block(18'h10000, 1'b1, -1, 1'b1);
    for (int i = 0; i < 64; i++) blk[i] = EW'(63 - i);
    run_block(18'h20020, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
